card_dealer: RTL and testbench
==============================

# card_dealer

Board-side companion of the memory-game turn FSM. It owns the 16-slot card board, shuffles 8 card pairs at start-up with an LFSR, and turns player button presses into card values `x` with a one-cycle `x_valid` strobe. It then samples the FSM's match (`j`) and player (`m`) outputs to retire matched pairs and keep per-player scores. It sits between the button/switch inputs and the turn FSM.

## Interface
- `SEED`, default `8'hA5`: LFSR reset value. A value of 0 is replaced by `8'h01`.
- `RESULT_DELAY`, default 2: cycles from the second `x_valid` to the sampling of `j`/`m`. Legal range 1–7.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `btnSelect` in 1: select button, already synchronized and debounced. Only its rising edge acts.
- `selection` in 4: board slot index 0–15.
- `new_game` in 1: level-sampled. Acted on only in DONE.
- `j` in 1: match flag from the turn FSM.
- `m` in 1: current player (0/1) from the turn FSM.
- `x` out 4: value of the last presented card.
- `x_valid` out 1: one-cycle strobe; `x` is new.
- `matched` out 16: bit i set means slot i is retired.
- `score0`, `score1` out 4 each: pairs won per player.
- `busy` out 1: high in SHUFFLE, WAIT and RESOLVE.
- `game_over` out 1: high in DONE.

## Operation
- Board: 16 × 4-bit registers. Reset/refill content is `board[i] = i>>1`, i.e. values 0–7, each twice.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts left, feedback into bit 0. It advances only in SHUFFLE.
- States: SHUFFLE, PICK1, PICK2, WAIT, RESOLVE, DONE.
- SHUFFLE:
  - Runs a counter k = 0..15. Each cycle it swaps `board[k]` and `board[lfsr[3:0]]`, then advances the LFSR.
  - After k = 15 it goes to PICK1.
  - k == `lfsr[3:0]` leaves the slot unchanged.
- Press edge: `rise = btnSelect & ~btn_q`, where `btn_q` is a 1-cycle delayed copy of `btnSelect`.
- PICK1:
  - `rise` with `matched[selection] == 0`: store `first = selection`, present the card, go to PICK2.
  - `rise` on a matched slot: ignored, no strobe.
- PICK2:
  - `rise` with the slot unmatched and `selection != first`: store `second`, present the card, load the wait counter with `RESULT_DELAY`, go to WAIT.
  - Repeated or matched slot: ignored.
- Present: `x <= board[sel]`, `x_valid <= 1` for exactly one cycle.
- WAIT: decrement the counter each cycle. At zero, go to RESOLVE.
- RESOLVE (1 cycle): sample `j` and `m`.
  - `j = 1`: set `matched[first]` and `matched[second]`, increment `score[m]`.
  - `j = 0`: no board change.
  - Next state: DONE if `matched` becomes all ones, else PICK1.
- DONE:
  - `new_game = 1`: clear `matched` and both scores, reload the board with its reset content, go to SHUFFLE.
  - The LFSR is not reseeded, so each game gets a new layout.
- Presses in SHUFFLE, WAIT, RESOLVE and DONE are dropped. They are not queued.
- Scores cannot exceed 8, so 4 bits never overflow. No saturation logic.

## Timing
- Reset values:
  - state SHUFFLE, k = 0, `lfsr = SEED` (or 1 if `SEED` is 0), board at reset content.
  - `x = 0`, `x_valid = 0`, `matched = 0`, `score0 = score1 = 0`.
  - `busy = 1`, `game_over = 0`, `btn_q = 0`.
- Shuffle takes 16 cycles after reset deassertion. PICK1 is active on cycle 17.
- Press latency:
  - Edge N is the first edge at which `btnSelect = 1` is sampled with `btn_q = 0`.
  - `x` and `x_valid` update at edge N and are valid for cycle N+1.
  - `x_valid` is low again after edge N+1.
- A held button produces one strobe only. A new press needs `btnSelect` low for at least one cycle.
- `j`/`m` are sampled at edge S + `RESULT_DELAY` + 1, where S is the second `x_valid` edge. `matched` and the scores update on that same edge.
- Reset assertion mid-game asynchronously returns every register to its reset value, including mid-shuffle and in WAIT.
- `selection` is sampled only on the `rise` edge. Changes at other times have no effect.

## Test plan
- Reset with `SEED = 8'hA5`, run 16 cycles → `busy` falls on cycle 17. Board read through 16 single picks (forced `j = 0`) matches the software LFSR model; each value 0–7 appears exactly twice.
- Pick slots whose values match, `m = 1`, drive `j = 1` at the sample edge → `matched` has both bits set, `score1 = 1`, `score0 = 0`, state PICK1.
- Pick slot 3 then slot 3 again → second press ignored, no `x_valid`. Then pick slot 5 → `x_valid` one cycle, `x = board[5]`.
- Hold `btnSelect` high for 10 cycles in PICK1 → exactly one `x_valid`. Presses during WAIT → dropped, no strobe.
- Play all 8 pairs with `j = 1` and alternating `m` → `score0 = 4`, `score1 = 4`, `matched = 16'hFFFF`, `game_over = 1`. Then `new_game` → `matched = 0`, new 16-cycle shuffle with a different layout.
- Assert `rst` low during SHUFFLE (k = 7) and again in WAIT → all outputs at reset values immediately. After release, the shuffle restarts from k = 0 with the `SEED` layout.

Source files
------------

// File: rtl/card_dealer.sv
// Board-side companion of the memory-game turn FSM: shuffles 8 card pairs with an LFSR,
// presents picked cards as x/x_valid, and retires matched pairs while keeping scores.
module card_dealer #(
    parameter logic [7:0] SEED         = 8'hA5,
    parameter int         RESULT_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnSelect,
    input  logic [3:0]  selection,
    input  logic        new_game,
    input  logic        j,
    input  logic        m,
    output logic [3:0]  x,
    output logic        x_valid,
    output logic [15:0] matched,
    output logic [3:0]  score0,
    output logic [3:0]  score1,
    output logic        busy,
    output logic        game_over
);

    typedef enum logic [2:0] {
        SHUFFLE,
        PICK1,
        PICK2,
        WAIT,
        RESOLVE,
        DONE
    } stateType;

    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [2:0] DELAY    = 3'(RESULT_DELAY);

    stateType    state;
    logic [3:0]  board [16];
    logic [7:0]  lfsr;
    logic [3:0]  k;
    logic [3:0]  first;
    logic [3:0]  second;
    logic [2:0]  waitCnt;
    logic        btnQ;

    logic        rise;
    logic        selFree;
    logic [3:0]  swapIdx;
    logic [7:0]  lfsrNext;
    logic [2:0]  waitNext;
    logic [15:0] matchedNext;

    always_comb begin
        rise        = btnSelect & ~btnQ;
        selFree     = ~matched[selection];
        swapIdx     = lfsr[3:0];
        // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3.
        lfsrNext    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        waitNext    = waitCnt - 3'd1;
        matchedNext = matched | (16'b1 << first) | (16'b1 << second);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SHUFFLE;
            lfsr      <= SEED_EFF;
            k         <= 4'd0;
            first     <= 4'd0;
            second    <= 4'd0;
            waitCnt   <= 3'd0;
            btnQ      <= 1'b0;
            x         <= 4'd0;
            x_valid   <= 1'b0;
            matched   <= 16'd0;
            score0    <= 4'd0;
            score1    <= 4'd0;
            busy      <= 1'b1;
            game_over <= 1'b0;
            // NOTE: the board is a register file with a defined reset layout, so it is
            // reset explicitly; it is too small and too live to be a RAM macro anyway.
            for (int i = 0; i < 16; i++) begin
                board[i] <= 4'(i >> 1);
            end
        end else begin
            btnQ    <= btnSelect;
            // NOTE: non-blocking defaults followed by later assignments in the same block
            // are safe: the last scheduled update wins, giving a clean one-cycle strobe.
            x_valid <= 1'b0;

            case (state)
                SHUFFLE: begin
                    // When k equals swapIdx both writes carry the same value.
                    board[k]       <= board[swapIdx];
                    board[swapIdx] <= board[k];
                    lfsr           <= lfsrNext;
                    k              <= k + 4'd1;
                    if (k == 4'd15) begin
                        state <= PICK1;
                        busy  <= 1'b0;
                    end
                end

                PICK1: begin
                    if (rise && selFree) begin
                        first   <= selection;
                        x       <= board[selection];
                        x_valid <= 1'b1;
                        state   <= PICK2;
                    end
                end

                PICK2: begin
                    if (rise && selFree && (selection != first)) begin
                        second  <= selection;
                        x       <= board[selection];
                        x_valid <= 1'b1;
                        waitCnt <= DELAY;
                        state   <= WAIT;
                        busy    <= 1'b1;
                    end
                end

                WAIT: begin
                    waitCnt <= waitNext;
                    if (waitNext == 3'd0) begin
                        state <= RESOLVE;
                    end
                end

                RESOLVE: begin
                    if (j) begin
                        matched <= matchedNext;
                        if (m) begin
                            score1 <= score1 + 4'd1;
                        end else begin
                            score0 <= score0 + 4'd1;
                        end
                    end
                    busy <= 1'b0;
                    if (j && (matchedNext == 16'hFFFF)) begin
                        state     <= DONE;
                        game_over <= 1'b1;
                    end else begin
                        state <= PICK1;
                    end
                end

                DONE: begin
                    if (new_game) begin
                        matched   <= 16'd0;
                        score0    <= 4'd0;
                        score1    <= 4'd0;
                        k         <= 4'd0;
                        state     <= SHUFFLE;
                        busy      <= 1'b1;
                        game_over <= 1'b0;
                        for (int i = 0; i < 16; i++) begin
                            board[i] <= 4'(i >> 1);
                        end
                    end
                end

                default: begin
                    state <= SHUFFLE;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: shuffle timing, card presentation, pair resolution,
// end of game, restart and mid-game reset.
module tb_card_dealer;

    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        btnSelect;
    logic [3:0]  selection;
    logic        new_game;
    logic        j;
    logic        m;
    logic [3:0]  x;
    logic        x_valid;
    logic [15:0] matched;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic        busy;
    logic        game_over;

    card_dealer #(.SEED(SEED), .RESULT_DELAY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .btnSelect (btnSelect),
        .selection (selection),
        .new_game  (new_game),
        .j         (j),
        .m         (m),
        .x         (x),
        .x_valid   (x_valid),
        .matched   (matched),
        .score0    (score0),
        .score1    (score1),
        .busy      (busy),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    logic [7:0]  modelLfsr;
    logic [3:0]  modelBoard [16];
    logic [3:0]  obsBoard [16];
    logic [15:0] expMatched;
    int          expS0;
    int          expS1;
    int          pairA [8];
    int          pairB [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsrStep(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Software shuffle from the refill layout, continuing from modelLfsr.
    task automatic modelShuffle();
        logic [3:0] t;
        logic [3:0] r;
        for (int i = 0; i < 16; i++) modelBoard[i] = 4'(i / 2);
        for (int kk = 0; kk < 16; kk++) begin
            r = modelLfsr[3:0];
            t = modelBoard[kk];
            modelBoard[kk] = modelBoard[r];
            modelBoard[r] = t;
            modelLfsr = lfsrStep(modelLfsr);
        end
        for (int v = 0; v < 8; v++) pairA[v] = -1;
        for (int i = 0; i < 16; i++) begin
            if (pairA[modelBoard[i]] < 0) pairA[modelBoard[i]] = i;
            else pairB[modelBoard[i]] = i;
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, " x"}, 32'(x), 0);
        check({tag, " x_valid"}, 32'(x_valid), 0);
        check({tag, " matched"}, 32'(matched), 0);
        check({tag, " score0"}, 32'(score0), 0);
        check({tag, " score1"}, 32'(score1), 0);
        check({tag, " busy"}, 32'(busy), 1);
        check({tag, " game_over"}, 32'(game_over), 0);
    endtask

    task automatic waitShuffle(input string tag);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            check({tag, " busy"}, 32'(busy), 32'(i < 16));
        end
        check({tag, " game_over"}, 32'(game_over), 0);
    endtask

    task automatic press(input logic [3:0] sel, input bit expStrobe, input logic [3:0] expVal,
                         input string tag);
        selection = sel;
        btnSelect = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " strobe"}, 32'(x_valid), 32'(expStrobe));
        if (expStrobe) begin
            check({tag, " x"}, 32'(x), 32'(expVal));
            obsBoard[sel] = x;
        end
        btnSelect = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " strobe low"}, 32'(x_valid), 0);
    endtask

    // Called one edge after the second strobe; j/m are only valid right before the sample edge.
    task automatic finishTurn(input logic [3:0] a, input logic [3:0] b, input bit jv, input bit mv,
                              input bit poke, input string tag);
        j = 1'b0;
        m = ~mv;
        if (poke) begin
            selection = a;
            btnSelect = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, " wait busy"}, 32'(busy), 1);
        check({tag, " wait matched"}, 32'(matched), 32'(expMatched));
        check({tag, " wait strobe"}, 32'(x_valid), 0);
        j = jv;
        m = mv;
        @(posedge clk);
        #1;
        if (jv) begin
            expMatched = expMatched | (16'b1 << a) | (16'b1 << b);
            if (mv) expS1++;
            else expS0++;
        end
        check({tag, " matched"}, 32'(matched), 32'(expMatched));
        check({tag, " score0"}, 32'(score0), 32'(expS0));
        check({tag, " score1"}, 32'(score1), 32'(expS1));
        check({tag, " strobe"}, 32'(x_valid), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " game_over"}, 32'(game_over), 32'(expMatched == 16'hFFFF));
        j = 1'b0;
        btnSelect = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic turn(input logic [3:0] a, input logic [3:0] b, input bit jv, input bit mv,
                        input string tag);
        press(a, 1'b1, modelBoard[a], {tag, " first"});
        press(b, 1'b1, modelBoard[b], {tag, " second"});
        finishTurn(a, b, jv, mv, 1'b0, tag);
    endtask

    task automatic readBoard(input string tag);
        int cnt [16];
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        for (int t = 0; t < 8; t++) turn(4'(2 * t), 4'(2 * t + 1), 1'b0, 1'b0, tag);
        for (int i = 0; i < 16; i++) cnt[obsBoard[i]]++;
        for (int v = 0; v < 8; v++) check($sformatf("%s count of %0d", tag, v), 32'(cnt[v]), 2);
    endtask

    int strobes;

    initial begin
        rst = 1'b0;
        btnSelect = 1'b0;
        selection = 4'd0;
        new_game = 1'b0;
        j = 1'b0;
        m = 1'b0;
        for (int i = 0; i < 16; i++) obsBoard[i] = 4'd0;
        modelLfsr = SEED;
        modelShuffle();
        expMatched = 16'd0;
        expS0 = 0;
        expS1 = 0;

        #22;
        checkReset("reset");
        @(negedge clk);
        rst = 1'b1;
        waitShuffle("shuffle1");
        readBoard("game1 read");

        // Repeated slot is ignored; a press during WAIT is dropped.
        press(4'd3, 1'b1, modelBoard[3], "pick3");
        press(4'd3, 1'b0, 4'd0, "repeat3");
        press(4'd5, 1'b1, modelBoard[5], "pick5");
        finishTurn(4'd3, 4'd5, 1'b0, 1'b0, 1'b1, "turn3/5 poke");

        // A held button gives a single strobe.
        selection = 4'd6;
        btnSelect = 1'b1;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (x_valid) strobes++;
        end
        check("hold strobes", 32'(strobes), 1);
        check("hold x", 32'(x), 32'(modelBoard[6]));
        btnSelect = 1'b0;
        @(posedge clk);
        #1;
        press(4'd7, 1'b1, modelBoard[7], "hold second");
        finishTurn(4'd6, 4'd7, 1'b0, 1'b0, 1'b0, "hold turn");

        turn(4'(pairA[0]), 4'(pairB[0]), 1'b1, 1'b1, "pair0");
        check("pair0 score1 const", 32'(score1), 1);
        check("pair0 score0 const", 32'(score0), 0);
        for (int v = 1; v < 8; v++)
            turn(4'(pairA[v]), 4'(pairB[v]), 1'b1, (v % 2 == 0), $sformatf("pair%0d", v));
        check("final score0", 32'(score0), 4);
        check("final score1", 32'(score1), 4);
        check("final matched", 32'(matched), 32'h0000FFFF);
        check("final game_over", 32'(game_over), 1);
        check("final busy", 32'(busy), 0);
        press(4'd0, 1'b0, 4'd0, "done press");

        modelShuffle();
        new_game = 1'b1;
        @(posedge clk);
        #1;
        new_game = 1'b0;
        check("new_game matched", 32'(matched), 0);
        check("new_game score0", 32'(score0), 0);
        check("new_game score1", 32'(score1), 0);
        check("new_game busy", 32'(busy), 1);
        check("new_game game_over", 32'(game_over), 0);
        expMatched = 16'd0;
        expS0 = 0;
        expS1 = 0;
        waitShuffle("shuffle2");
        readBoard("game2 read");

        // Reset mid-shuffle at k = 7, then the SEED layout must come back.
        rst = 1'b0;
        #1;
        checkReset("reset in pick1");
        @(negedge clk);
        rst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkReset("reset at k7");
        modelLfsr = SEED;
        modelShuffle();
        @(negedge clk);
        rst = 1'b1;
        waitShuffle("shuffle3");
        readBoard("seed layout");

        // Reset while in WAIT.
        turn(4'(pairA[2]), 4'(pairB[2]), 1'b1, 1'b0, "pre-reset pair");
        press(4'(pairA[3]), 1'b1, modelBoard[pairA[3]], "wait reset first");
        press(4'(pairB[3]), 1'b1, modelBoard[pairB[3]], "wait reset second");
        rst = 1'b0;
        #1;
        checkReset("reset in wait");
        modelLfsr = SEED;
        modelShuffle();
        expMatched = 16'd0;
        expS0 = 0;
        expS1 = 0;
        @(negedge clk);
        rst = 1'b1;
        waitShuffle("shuffle4");
        press(4'd0, 1'b1, modelBoard[0], "post-reset pick");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
